// File: rtl/boc_acq_search.sv
// Code-phase search controller for B1 BOC acquisition: tracks the correlation peak
// across a full code sweep from NCH parallel correlators and applies a detection threshold.
module boc_acq_search #(
  parameter int NCH           = 4,
  parameter int CORR_WIDTH    = 32,
  parameter int PRN_PHS_WIDTH = 12,
  parameter int CODE_LEN      = 4092
) (
  input  logic                      rx_clk,
  input  logic                      rx_rst_n,
  input  logic                      rx_start,
  input  logic [CORR_WIDTH-1:0]     rx_thresh,
  input  logic [NCH*CORR_WIDTH-1:0] rx_corr_acc,
  input  logic [NCH-1:0]            rx_corr_vld,
  output logic                      tx_corr_clr,
  output logic                      tx_busy,
  output logic                      tx_done,
  output logic                      tx_acq_suc,
  output logic [PRN_PHS_WIDTH-1:0]  tx_acq_phs,
  output logic [CORR_WIDTH-1:0]     tx_acq_peak
);

  localparam int CNT_W = PRN_PHS_WIDTH + 1;
  localparam logic [CNT_W-1:0] CODE_LEN_C = CNT_W'(CODE_LEN);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEARCH,
    ST_DONE
  } state_t;

  state_t                   state;
  state_t                   state_nxt;

  logic [CORR_WIDTH-1:0]    thresh_q;
  logic [CORR_WIDTH-1:0]    peak;
  logic [PRN_PHS_WIDTH-1:0] pk_phs;
  logic [CNT_W-1:0]         count;
  logic [PRN_PHS_WIDTH-1:0] ch_phs [NCH];

  logic                     start_acc;
  logic [NCH-1:0]           ch_valid;
  logic [CNT_W-1:0]         n_valid;
  logic [CNT_W-1:0]         count_nxt;
  logic                     cand_found;
  logic [CORR_WIDTH-1:0]    cand;
  logic [PRN_PHS_WIDTH-1:0] cand_phs;
  logic [CORR_WIDTH-1:0]    peak_nxt;
  logic [PRN_PHS_WIDTH-1:0] pk_phs_nxt;
  logic                     sweep_end;

  // Phase advance saturates so a channel that keeps strobing past the end of
  // the code can never wrap back into the valid range.
  function automatic logic [PRN_PHS_WIDTH-1:0] phs_step(input logic [PRN_PHS_WIDTH-1:0] p);
    logic [PRN_PHS_WIDTH:0] s;
    s = {1'b0, p} + (PRN_PHS_WIDTH+1)'(NCH);
    return s[PRN_PHS_WIDTH] ? '1 : s[PRN_PHS_WIDTH-1:0];
  endfunction

  // Per-cycle candidate: ascending scan with strict compare keeps the lowest channel on ties.
  always_comb begin
    ch_valid   = '0;
    n_valid    = '0;
    cand_found = 1'b0;
    cand       = '0;
    cand_phs   = '0;
    for (int i = 0; i < NCH; i++) begin
      ch_valid[i] = rx_corr_vld[i] && (CNT_W'(ch_phs[i]) < CODE_LEN_C);
      if (ch_valid[i]) begin
        n_valid = n_valid + CNT_W'(1);
        if (!cand_found || (rx_corr_acc[i*CORR_WIDTH +: CORR_WIDTH] > cand)) begin
          cand_found = 1'b1;
          cand       = rx_corr_acc[i*CORR_WIDTH +: CORR_WIDTH];
          cand_phs   = ch_phs[i];
        end
      end
    end
  end

  always_comb begin
    start_acc  = rx_start && (state != ST_SEARCH);
    count_nxt  = count + n_valid;
    sweep_end  = (state == ST_SEARCH) && (count_nxt >= CODE_LEN_C);
    peak_nxt   = peak;
    pk_phs_nxt = pk_phs;
    if (cand_found && (cand > peak)) begin
      peak_nxt   = cand;
      pk_phs_nxt = cand_phs;
    end
    state_nxt = state;
    case (state)
      ST_IDLE:   if (start_acc) state_nxt = ST_SEARCH;
      ST_SEARCH: if (sweep_end) state_nxt = ST_DONE;
      ST_DONE:   if (start_acc) state_nxt = ST_SEARCH;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge rx_clk or negedge rx_rst_n) begin
    if (!rx_rst_n) state <= ST_IDLE;
    else           state <= state_nxt;
  end

  assign tx_busy = (state == ST_SEARCH);

  always_ff @(posedge rx_clk or negedge rx_rst_n) begin
    if (!rx_rst_n) begin
      thresh_q    <= '0;
      peak        <= '0;
      pk_phs      <= '0;
      count       <= '0;
      for (int i = 0; i < NCH; i++) ch_phs[i] <= PRN_PHS_WIDTH'(i);
      tx_corr_clr <= 1'b0;
      tx_done     <= 1'b0;
      tx_acq_suc  <= 1'b0;
      tx_acq_phs  <= '0;
      tx_acq_peak <= '0;
    end else begin
      tx_corr_clr <= start_acc;
      tx_done     <= sweep_end;
      if (start_acc) begin
        // pk_phs is cleared too so a sweep that never beats zero reports phase 0
        thresh_q    <= rx_thresh;
        peak        <= '0;
        pk_phs      <= '0;
        count       <= '0;
        for (int i = 0; i < NCH; i++) ch_phs[i] <= PRN_PHS_WIDTH'(i);
        tx_acq_suc  <= 1'b0;
        tx_acq_phs  <= '0;
        tx_acq_peak <= '0;
      end else if (state == ST_SEARCH) begin
        count  <= count_nxt;
        peak   <= peak_nxt;
        pk_phs <= pk_phs_nxt;
        for (int i = 0; i < NCH; i++) begin
          if (rx_corr_vld[i]) ch_phs[i] <= phs_step(ch_phs[i]);
        end
        if (sweep_end) begin
          tx_acq_peak <= peak_nxt;
          tx_acq_phs  <= pk_phs_nxt;
          tx_acq_suc  <= (peak_nxt >= thresh_q);
        end
      end
    end
  end

endmodule

// File: tb/tb_boc_acq_search.sv
// Directed bench for boc_acq_search: two instances (CODE_LEN 4092 and 4094) share
// stimulus; table of full sweeps plus hand-written restart/reset sequences.
module tb_boc_acq_search;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic [31:0]  thresh = '0;
  logic [127:0] acc = '0;
  logic [3:0]   vld = '0;

  logic         clr_a, busy_a, done_a, suc_a;
  logic [11:0]  phs_a;
  logic [31:0]  peak_a;
  logic         clr_b, busy_b, done_b, suc_b;
  logic [12:0]  phs_b;
  logic [31:0]  peak_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  boc_acq_search #(.NCH(4), .CORR_WIDTH(32), .PRN_PHS_WIDTH(12), .CODE_LEN(4092)) dut_a (
    .rx_clk(clk), .rx_rst_n(rst_n), .rx_start(start), .rx_thresh(thresh),
    .rx_corr_acc(acc), .rx_corr_vld(vld), .tx_corr_clr(clr_a), .tx_busy(busy_a),
    .tx_done(done_a), .tx_acq_suc(suc_a), .tx_acq_phs(phs_a), .tx_acq_peak(peak_a)
  );

  boc_acq_search #(.NCH(4), .CORR_WIDTH(32), .PRN_PHS_WIDTH(13), .CODE_LEN(4094)) dut_b (
    .rx_clk(clk), .rx_rst_n(rst_n), .rx_start(start), .rx_thresh(thresh),
    .rx_corr_acc(acc), .rx_corr_vld(vld), .tx_corr_clr(clr_b), .tx_busy(busy_b),
    .tx_done(done_b), .tx_acq_suc(suc_b), .tx_acq_phs(phs_b), .tx_acq_peak(peak_b)
  );

  typedef struct {
    logic [31:0] thresh;
    int          pat;
    bit          gaps;
    bit          mid_start;
    logic        exp_suc_a;
    logic [11:0] exp_phs_a;
    logic [31:0] exp_peak_a;
    logic        exp_suc_b;
    logic [12:0] exp_phs_b;
    logic [31:0] exp_peak_b;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Correlation magnitude reported for a code phase; 4094/4095 exist only past CODE_LEN.
  function automatic logic [31:0] val(input int pat, input int p);
    if (p >= 4094) return 32'd9999;
    case (pat)
      0:       return (p == 1022) ? 32'd1000 : 32'd10;
      1:       return (p == 9 || p == 11 || p == 2001) ? 32'd700 : 32'd10;
      2:       return 32'(p + 1);
      3:       return 32'd0;
      default: return (p == 3000) ? 32'hFFFF_FFFF : (p == 5) ? 32'h8000_0000 : 32'd10;
    endcase
  endfunction

  task automatic drive_k(input int pat, input int k);
    vld = 4'hf;
    for (int i = 0; i < 4; i++) acc[i*32 +: 32] = val(pat, 4*k + i);
  endtask

  task automatic run_sweep(input vec_t v, input int id);
    int k, da, db, tail;
    logic        cs_a, cs_b;
    logic [11:0] cp_a;
    logic [12:0] cp_b;
    logic [31:0] ck_a, ck_b;
    k = 0; da = 0; db = 0; tail = 0;
    cs_a = 0; cs_b = 0; cp_a = '0; cp_b = '0; ck_a = '0; ck_b = '0;
    // start cycle carries huge strobed values that must be ignored
    @(negedge clk);
    thresh = v.thresh; start = 1'b1; vld = 4'hf; acc = {4{32'hFFFF_FFFF}};
    @(negedge clk);
    start = 1'b0; vld = '0;
    chk($sformatf("v%0d_clr_a", id), clr_a, 1);
    chk($sformatf("v%0d_clr_b", id), clr_b, 1);
    chk($sformatf("v%0d_busy_a", id), busy_a, 1);
    chk($sformatf("v%0d_done_a_t1", id), done_a, 0);
    chk($sformatf("v%0d_peak_a_clr", id), peak_a, 0);
    chk($sformatf("v%0d_phs_b_clr", id), phs_b, 0);
    chk($sformatf("v%0d_suc_b_clr", id), suc_b, 0);
    for (int cyc = 0; cyc < 3000 && tail < 3; cyc++) begin
      start = (v.mid_start && cyc == 100);
      if ((v.gaps && (cyc % 5) == 3) || k > 1023) begin
        vld = '0; acc = {4{32'h1234_5678}};
      end else begin
        drive_k(v.pat, k);
        k++;
      end
      @(negedge clk);
      if (cyc == 0) chk($sformatf("v%0d_clr_pulse", id), clr_a, 0);
      if (v.mid_start && cyc == 100) begin
        chk($sformatf("v%0d_midstart_clr", id), clr_a, 0);
        chk($sformatf("v%0d_midstart_busy", id), busy_a, 1);
      end
      if (done_a) begin
        da++; cs_a = suc_a; cp_a = phs_a; ck_a = peak_a;
        chk($sformatf("v%0d_busy_a_done", id), busy_a, 0);
      end
      if (done_b) begin
        db++; cs_b = suc_b; cp_b = phs_b; ck_b = peak_b;
      end
      if (da > 0 && db > 0) tail++;
    end
    start = 1'b0; vld = '0;
    chk($sformatf("v%0d_ndone_a", id), da, 1);
    chk($sformatf("v%0d_ndone_b", id), db, 1);
    chk($sformatf("v%0d_suc_a", id), cs_a, v.exp_suc_a);
    chk($sformatf("v%0d_phs_a", id), cp_a, v.exp_phs_a);
    chk($sformatf("v%0d_peak_a", id), ck_a, v.exp_peak_a);
    chk($sformatf("v%0d_suc_b", id), cs_b, v.exp_suc_b);
    chk($sformatf("v%0d_phs_b", id), cp_b, v.exp_phs_b);
    chk($sformatf("v%0d_peak_b", id), ck_b, v.exp_peak_b);
    chk($sformatf("v%0d_held_peak_a", id), peak_a, v.exp_peak_a);
    chk($sformatf("v%0d_held_phs_b", id), phs_b, v.exp_phs_b);
  endtask

  initial begin
    int nd;
    tbl[0] = '{32'd500,         0, 1'b0, 1'b0, 1'b1, 12'd1022, 32'd1000,      1'b1, 13'd1022, 32'd1000};
    tbl[1] = '{32'd2000,        0, 1'b1, 1'b0, 1'b0, 12'd1022, 32'd1000,      1'b0, 13'd1022, 32'd1000};
    tbl[2] = '{32'd700,         1, 1'b0, 1'b0, 1'b1, 12'd9,    32'd700,       1'b1, 13'd9,    32'd700};
    tbl[3] = '{32'd4094,        2, 1'b1, 1'b1, 1'b0, 12'd4091, 32'd4092,      1'b1, 13'd4093, 32'd4094};
    tbl[4] = '{32'd0,           3, 1'b0, 1'b0, 1'b1, 12'd0,    32'd0,         1'b1, 13'd0,    32'd0};
    tbl[5] = '{32'hFFFF_FFFF,   4, 1'b0, 1'b0, 1'b1, 12'd3000, 32'hFFFF_FFFF, 1'b1, 13'd3000, 32'hFFFF_FFFF};

    #2 rst_n = 1'b0;
    #1;
    chk("rst_clr", clr_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_suc", suc_a, 0);
    chk("rst_phs", phs_a, 0);
    chk("rst_peak", peak_b, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) run_sweep(tbl[i], i);

    // Async reset while DONE holds a result
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_done_peak", peak_a, 0);
    chk("arst_done_phs", phs_a, 0);
    chk("arst_done_suc", suc_b, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset in the middle of a sweep
    @(negedge clk);
    thresh = 32'd500; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 50; k++) begin
      drive_k(0, k);
      @(negedge clk);
    end
    chk("mid_busy_before", busy_a, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy_a", busy_a, 0);
    chk("mid_rst_busy_b", busy_b, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    for (int k = 0; k < 1100; k++) begin
      drive_k(0, k % 1024);
      @(negedge clk);
      if (done_a || done_b || busy_a || busy_b) nd++;
    end
    vld = '0;
    chk("idle_after_rst", nd, 0);
    run_sweep(tbl[0], 9);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
